// File: rtl/seg7_pkg.sv
// seg7_pkg: shared state type and constants for the 7-segment scan controller
package seg7_pkg;
    typedef enum logic [1:0] {IDLE, ON, BLANK} state_t;
    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam int NUM_DIGITS = 4;
endpackage

// File: rtl/seg7_lz_mask.sv
// seg7_lz_mask: leading-zero blank mask for the four displayed BCD digits
//   lz_blank : blanking enable
//   active   : displayed value, nibble n is digit n
//   mask     : bit n set -> digit n stays dark during its ON phase
module seg7_lz_mask
    import seg7_pkg::*;
(
    input  logic                  lz_blank,
    input  logic [15:0]           active,
    output logic [NUM_DIGITS-1:0] mask
);
    logic z3, z2, z1;
    assign z3 = lz_blank && active[15:12] == 4'h0;
    assign z2 = z3 && active[11:8] == 4'h0;
    assign z1 = z2 && active[7:4] == 4'h0;
    // digit 0 always lights so an all-zero value still shows a single 0
    assign mask = {z3, z2, z1, 1'b0};
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 4-digit 7-segment scan with double-buffered load
//   clk_in, rst_n : clock, synchronous active-low reset
//   en            : scan enable (low -> IDLE)
//   lz_blank      : leading-zero blanking enable
//   load_req/load_rdy, data_in : load handshake into the shadow register
//   scan_an       : active-low anodes, digit_out : nibble of selected digit
//   frame_done    : one-cycle pulse at the end of each 4-digit frame
//   SEG7_SCAN_DIM_EN : adds 2-bit dim input shortening the lit part of ON
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYC = 40,
    parameter int BLANK_CYC = 2
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        en,
    input  logic        lz_blank,
    input  logic        load_req,
    input  logic [15:0] data_in,
`ifdef SEG7_SCAN_DIM_EN
    input  logic [1:0]  dim,
`endif
    output logic        load_rdy,
    output logic [3:0]  scan_an,
    output logic [3:0]  digit_out,
    output logic        frame_done
);
    localparam int MAXC = DIGIT_CYC > BLANK_CYC ? DIGIT_CYC : BLANK_CYC;
    localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] ON_LAST = CW'(DIGIT_CYC - 1);
    localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYC - 1);
    state_t state;
    logic [1:0] idx;
    logic [CW-1:0] cnt;
    logic [15:0] active, shadow;
    logic pending, frame_end, lit;
    logic [3:0] mask;
    assign frame_end = state == BLANK && idx == 2'(NUM_DIGITS - 1) && cnt == BL_LAST;
`ifdef SEG7_SCAN_DIM_EN
    logic [1:0] dim_q;
    assign lit = 32'(cnt) < ((32'(dim_q) + 32'd1) * DIGIT_CYC) / 4;
`else
    assign lit = 1'b1;
`endif
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state <= IDLE;
            idx <= '0;
            cnt <= '0;
            active <= '0;
            shadow <= '0;
            pending <= 1'b0;
`ifdef SEG7_SCAN_DIM_EN
            dim_q <= '0;
`endif
        end else begin
            if (!en) begin
                state <= IDLE;
                idx <= '0;
                cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ON;
                        cnt <= '0;
`ifdef SEG7_SCAN_DIM_EN
                        dim_q <= dim;
`endif
                    end
                    ON: begin
                        state <= cnt == ON_LAST ? BLANK : ON;
                        cnt <= cnt == ON_LAST ? '0 : cnt + 1'b1;
                    end
                    BLANK: begin
                        state <= cnt == BL_LAST ? ON : BLANK;
                        cnt <= cnt == BL_LAST ? '0 : cnt + 1'b1;
                        idx <= cnt == BL_LAST ? idx + 1'b1 : idx;
`ifdef SEG7_SCAN_DIM_EN
                        if (cnt == BL_LAST) dim_q <= dim;
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
            // accept needs !pending and the swap needs pending, so they never collide
            if (load_req && !pending) begin
                shadow <= data_in;
                pending <= 1'b1;
            end else if (pending && (state == IDLE || frame_end)) begin
                active <= shadow;
                pending <= 1'b0;
            end
        end
    end
    seg7_lz_mask u_lz (
        .lz_blank(lz_blank),
        .active  (active),
        .mask    (mask)
    );
    assign load_rdy = !pending;
    assign frame_done = frame_end;
    assign digit_out = active[{idx, 2'b00} +: 4];
    assign scan_an = (state == ON && !mask[idx] && lit) ? ~(4'b0001 << idx) : ANODE_OFF;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;
    localparam int DC = 40;
    localparam int BC = 2;
    localparam int DP = DC + BC;
    localparam int FP = 4 * DP;
    logic clk_in = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic lz_blank = 1'b0;
    logic load_req = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic load_rdy, frame_done;
    logic [3:0] scan_an, digit_out;
`ifdef SEG7_SCAN_DIM_EN
    logic [1:0] dim = 2'd3;
`endif
    int checks = 0;
    int errors = 0;
    always #5 clk_in = ~clk_in;
    seg7_scan_ctrl #(.DIGIT_CYC(DC), .BLANK_CYC(BC)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .en        (en),
        .lz_blank  (lz_blank),
        .load_req  (load_req),
        .data_in   (data_in),
`ifdef SEG7_SCAN_DIM_EN
        .dim       (dim),
`endif
        .load_rdy  (load_rdy),
        .scan_an   (scan_an),
        .digit_out (digit_out),
        .frame_done(frame_done)
    );
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    // expected outputs at position k of a frame, k=0 being the first ON cycle of digit 0
    task automatic chk_cycle(input int k, input logic [15:0] act, input logic [3:0] blank, input int onlen);
        int d, ph;
        logic [3:0] an;
        d = k / DP;
        ph = k % DP;
        an = (ph < onlen && !blank[d]) ? ~(4'b0001 << d) : 4'b1111;
        check($sformatf("scan_an k=%0d", k), 16'(scan_an), 16'(an));
        check($sformatf("digit_out k=%0d", k), 16'(digit_out), 16'(4'(act >> (4 * d))));
        check($sformatf("frame_done k=%0d", k), 16'(frame_done), 16'(k == FP - 1));
    endtask
    initial begin
        repeat (2) @(negedge clk_in);
        check("rst scan_an", 16'(scan_an), 16'hF);
        check("rst digit_out", 16'(digit_out), 16'h0);
        check("rst load_rdy", 16'(load_rdy), 16'h1);
        check("rst frame_done", 16'(frame_done), 16'h0);
        rst_n = 1'b1;
        data_in = 16'h1234;
        load_req = 1'b1;
        @(negedge clk_in);
        check("load_rdy after accept", 16'(load_rdy), 16'h0);
        load_req = 1'b0;
        @(negedge clk_in);
        check("load_rdy after idle copy", 16'(load_rdy), 16'h1);
        check("idle digit_out", 16'(digit_out), 16'h4);
        check("idle scan_an", 16'(scan_an), 16'hF);
        en = 1'b1;
        @(negedge clk_in);
        for (int k = 0; k < FP; k++) begin
            chk_cycle(k, 16'h1234, 4'b0000, DC);
            @(negedge clk_in);
        end
        for (int k = 0; k < FP; k++) begin
            chk_cycle(k, 16'h1234, 4'b0000, DC);
            if (k == 50) begin
                load_req = 1'b1;
                data_in = 16'h5678;
            end
            if (k == 51) begin
                check("load_rdy pending", 16'(load_rdy), 16'h0);
                data_in = 16'h9999;
            end
            if (k == 52) load_req = 1'b0;
            if (k == FP - 1) check("load_rdy at frame_done", 16'(load_rdy), 16'h0);
            @(negedge clk_in);
        end
        check("load_rdy after swap", 16'(load_rdy), 16'h1);
        for (int k = 0; k < FP; k++) begin
            chk_cycle(k, 16'h5678, 4'b0000, DC);
            if (k == 10) begin
                load_req = 1'b1;
                data_in = 16'h0070;
            end
            if (k == 11) load_req = 1'b0;
            if (k == FP - 1) lz_blank = 1'b1;
            @(negedge clk_in);
        end
        for (int k = 0; k < FP; k++) begin
            chk_cycle(k, 16'h0070, 4'b1100, DC);
            if (k == FP - 1) lz_blank = 1'b0;
            @(negedge clk_in);
        end
        for (int k = 0; k <= 90; k++) begin
            chk_cycle(k, 16'h0070, 4'b0000, DC);
            if (k == 90) en = 1'b0;
            @(negedge clk_in);
        end
        check("en drop scan_an", 16'(scan_an), 16'hF);
        check("en drop frame_done", 16'(frame_done), 16'h0);
        check("en drop digit_out", 16'(digit_out), 16'h0);
        @(negedge clk_in);
        check("idle hold frame_done", 16'(frame_done), 16'h0);
        en = 1'b1;
        @(negedge clk_in);
        for (int k = 0; k <= 40; k++) begin
            chk_cycle(k, 16'h0070, 4'b0000, DC);
            if (k == 40) begin
                load_req = 1'b1;
                data_in = 16'hABCD;
            end
            @(negedge clk_in);
        end
        chk_cycle(41, 16'h0070, 4'b0000, DC);
        check("pending before reset", 16'(load_rdy), 16'h0);
        load_req = 1'b0;
        rst_n = 1'b0;
        en = 1'b0;
        @(negedge clk_in);
        check("mid rst scan_an", 16'(scan_an), 16'hF);
        check("mid rst digit_out", 16'(digit_out), 16'h0);
        check("mid rst load_rdy", 16'(load_rdy), 16'h1);
        check("mid rst frame_done", 16'(frame_done), 16'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_in);
        check("pending discarded digit_out", 16'(digit_out), 16'h0);
        check("pending discarded load_rdy", 16'(load_rdy), 16'h1);
        en = 1'b1;
        @(negedge clk_in);
        for (int k = 0; k < FP; k++) begin
            chk_cycle(k, 16'h0000, 4'b0000, DC);
`ifdef SEG7_SCAN_DIM_EN
            if (k == FP - 1) dim = 2'd1;
`endif
            @(negedge clk_in);
        end
`ifdef SEG7_SCAN_DIM_EN
        for (int k = 0; k < FP; k++) begin
            chk_cycle(k, 16'h0000, 4'b0000, 20);
            @(negedge clk_in);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter DIGIT_CYC, default 40: clk_in cycles each digit spends in ON phase; legal >= 4.
REQ-002 Parameter BLANK_CYC, default 2: clk_in cycles of all-anodes-off after each digit (anti-ghosting); legal >= 1.
REQ-003 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  one clock; reset is synchronous and active-low.
REQ-005 en  input  1  scan enable; low forces IDLE.
REQ-006 lz_blank  input  1  leading-zero blanking enable.
REQ-007 load_req  input  1  request to load data_in.
REQ-008 data_in  input  16  four BCD nibbles; [3:0] is digit 0, [15:12] is digit 3.
REQ-009 load_rdy  output  1  high when no load is pending.
REQ-010 scan_an  output  4  active-low anode selects; bit n drives digit n.
REQ-011 digit_out  output  4  nibble of the currently selected digit.
REQ-012 frame_done  output  1  one-cycle pulse at the end of each full 4-digit frame.

Function
REQ-013 FSM states: IDLE, ON, BLANK. Outputs are Moore, decoded from registered state (zero added latency).
REQ-014 IDLE transitions to ON with digit index 0 on the first cycle en=1. Any state transitions to IDLE on the cycle after en=0 is sampled; index resets to 0.
REQ-015 ON lasts exactly DIGIT_CYC cycles, then BLANK. BLANK lasts exactly BLANK_CYC cycles, then ON with index+1 mod 4.
REQ-016 In ON, scan_an has only bit[index] low. In IDLE and BLANK, scan_an = 4'b1111.
REQ-017 digit_out = active-register nibble[index] in every state; nibbles above 9 pass through unchecked.
REQ-018 Load handshake: a load is accepted when load_req=1 and load_rdy=1. data_in is captured to the shadow register and load_rdy drops the next cycle. A load_req while load_rdy=0 is ignored; the requester holds until load_rdy=1.
REQ-019 The shadow register copies to the active register on the last BLANK cycle of digit 3, or on any cycle while in IDLE. load_rdy returns high the following cycle. The display never shows a mixed frame.
REQ-020 frame_done pulses on the last BLANK cycle of digit 3, coincident with the active-register update. It never pulses in IDLE.
REQ-021 With lz_blank=1, digits 3..1 whose nibble is 0 and that lie above the highest nonzero digit keep scan_an = 4'b1111 during their ON phase. Timing is unchanged. Digit 0 is never blanked.
REQ-022 Phase counter width is $clog2(max(DIGIT_CYC, BLANK_CYC)); it wraps to 0 on every state change.

Reset
REQ-023 With rst_n=0 at a clock edge, the next values are:
- state IDLE, index 0, counter 0
- active and shadow registers 16'h0000, pending cleared
- scan_an 4'b1111, digit_out 4'h0, load_rdy 1, frame_done 0
REQ-024 Reset mid-frame or mid-handshake discards the pending load. No frame_done is emitted.

Configuration
REQ-025 Macro SEG7_SCAN_DIM_EN defined: adds input dim (2 bits). In ON, the selected anode is low only for the first (dim+1)*DIGIT_CYC/4 cycles (integer division) and high for the rest. Phase timing is unchanged. dim is sampled at ON entry.
REQ-026 Macro SEG7_SCAN_DIM_EN undefined: no dim port; the anode is low for the whole ON phase.

Structure
REQ-027 Shared package seg7_pkg holds:
- state enum (IDLE, ON, BLANK)
- ANODE_OFF = 4'b1111
- NUM_DIGITS = 4
REQ-028 Sub-module seg7_lz_mask (combinational) computes the 4-bit blank mask from the active register and lz_blank.

Verification
REQ-029 Reset, then en=1, data 16'h0000 loaded as 16'h1234: after the first frame_done, scan_an cycles 1110,1101,1011,0111, each for 40 cycles with 2-cycle 1111 gaps; digit_out shows 4,3,2,1.
REQ-030 load_req of 16'h5678 mid-digit-1: load_rdy=0 next cycle; digit_out stays 1234-based until frame_done; load_rdy=1 the cycle after; a second req during pending is ignored.
REQ-031 lz_blank=1, data 16'h0070: digits 3 and 2 show scan_an 1111 through ON; digits 1 and 0 light; frame period stays 168 cycles.
REQ-032 en dropped during digit 2 ON: scan_an=1111 next cycle; en reasserted restarts at digit 0 with a full 40-cycle ON.
REQ-033 rst_n=0 for one cycle mid-BLANK with a pending load: all outputs at reset values, active=0000, no frame_done.
REQ-034 SEG7_SCAN_DIM_EN defined, dim=1: each anode low for 20 of 40 ON cycles; frame period unchanged.
